// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory controller.
package mem_pkg;

    localparam int MAX_WAIT_STATES = 15;

    // RV32I load/store width encodings (funct3).
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // True when the access is out of range, misaligned, an unknown width,
    // or a store that uses an unsigned-load encoding.
    function automatic logic access_fault(
        input logic        write,
        input logic [2:0]  funct3,
        input logic [31:0] address,
        input int unsigned depth
    );
        logic bad_range;
        logic bad_align;
        logic bad_code;
        bad_range = ({2'b00, address[31:2]} >= depth);
        bad_align = 1'b0;
        bad_code  = 1'b0;
        case (funct3)
            MEM_B:   bad_code  = 1'b0;
            MEM_H:   bad_align = address[0];
            MEM_W:   bad_align = |address[1:0];
            MEM_BU:  bad_code  = write;
            MEM_HU: begin
                bad_code  = write;
                bad_align = address[0];
            end
            default: bad_code  = 1'b1;
        endcase
        return bad_range | bad_align | bad_code;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the CPU datapath and the data memory.
interface data_memory_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_write, req_funct3, req_address, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_address, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );

endinterface

// File: rtl/lane_align.sv
// Byte-lane steering: extracts/extends load data from a word and merges
// store data into a word. Purely combinational.
module lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte and halfword of the word.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Extend load data and merge store data into the untouched bytes.
    always_comb begin
        load_value = word;
        store_word = word;
        case (funct3)
            MEM_B:  load_value = {{24{byte_sel[7]}}, byte_sel};
            MEM_BU: load_value = {24'h0, byte_sel};
            MEM_H:  load_value = {{16{half_sel[15]}}, half_sel};
            MEM_HU: load_value = {16'h0, half_sel};
            default: load_value = word;
        endcase
        case (funct3)
            MEM_B, MEM_BU: begin
                case (offset)
                    2'd0: store_word[7:0]   = wdata[7:0];
                    2'd1: store_word[15:8]  = wdata[7:0];
                    2'd2: store_word[23:16] = wdata[7:0];
                    2'd3: store_word[31:24] = wdata[7:0];
                    default: store_word = word;
                endcase
            end
            MEM_H, MEM_HU: begin
                if (offset[1]) store_word[31:16] = wdata[15:0];
                else           store_word[15:0]  = wdata[15:0];
            end
            MEM_W:   store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with RV32I sub-word access, programmable
// wait states and a fault response for illegal requests.
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    data_memory_ctrl_if.slave      bus,
    input  logic [DEPTH-1:0][31:0] initial_values,
    output logic [DEPTH-1:0][31:0] memory_check
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WS    = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
    localparam logic [3:0] WAIT_LOAD = (WS > 0) ? 4'(WS - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic        enter_resp;

    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;
    logic        fault_q;

    logic        cur_write;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [IDX_W-1:0] cur_index;
    logic        cur_fault;
    logic [31:0] load_value;
    logic [31:0] store_word;

    // Next-state and counter logic for IDLE -> WAIT -> RESP sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (WS == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request fields when it is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
        end else if (accept) begin
            write_q  <= bus.req_write;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_address;
            wdata_q  <= bus.req_wdata;
        end
    end

    // With zero wait states the access completes on the accepting edge, so
    // the live bus is used in IDLE and the captured copy otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            cur_write  = bus.req_write;
            cur_funct3 = bus.req_funct3;
            cur_addr   = bus.req_address;
            cur_wdata  = bus.req_wdata;
        end else begin
            cur_write  = write_q;
            cur_funct3 = funct3_q;
            cur_addr   = addr_q;
            cur_wdata  = wdata_q;
        end
    end

    assign cur_index = cur_addr[IDX_W+1:2];
    assign cur_fault = access_fault(cur_write, cur_funct3, cur_addr, DEPTH);

    lane_align u_lane_align (
        .word       (mem_q[cur_index]),
        .offset     (cur_addr[1:0]),
        .funct3     (cur_funct3),
        .wdata      (cur_wdata),
        .load_value (load_value),
        .store_word (store_word)
    );

    // Memory array and registered response, both updated on entry to RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is deliberately reset-loadable because reset
            // must restore the programmed contents; this costs a flop array
            // rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= initial_values[i];
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else if (enter_resp) begin
            fault_q <= cur_fault;
            rdata_q <= (cur_fault || cur_write) ? 32'h0 : load_value;
            if (!cur_fault && cur_write) mem_q[cur_index] <= store_word;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_check
        assign memory_check[g] = mem_q[g];
    end

    assign bus.req_ready  = (state_q == IDLE) && !reset;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed scenarios plus random
// traffic compared against a byte-addressed reference memory.
module tb_data_memory_ctrl;
    import mem_pkg::*;

    localparam int DEPTH = 32;
    localparam int WS    = 1;
    localparam int MEMW  = DEPTH * 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [DEPTH-1:0][31:0] iv;
    logic [DEPTH-1:0][31:0] mc;
    logic [DEPTH-1:0][31:0] mc0;

    data_memory_ctrl_if bus ();
    data_memory_ctrl_if bus0 ();

    data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .initial_values(iv), .memory_check(mc)
    );

    data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .initial_values(iv), .memory_check(mc0)
    );

    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;
    logic [31:0] last_rdata;
    logic        last_fault;
    logic [7:0]  model_bytes [DEPTH*4];

    task automatic check(input string tag, input logic [MEMW-1:0] obs, input logic [MEMW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++)
            for (int k = 0; k < 4; k++)
                model_bytes[4*i+k] = iv[i][8*k +: 8];
    endfunction

    function automatic logic [MEMW-1:0] model_words();
        logic [MEMW-1:0] w;
        w = '0;
        for (int b = 0; b < DEPTH*4; b++) w[8*b +: 8] = model_bytes[b];
        return w;
    endfunction

    // Reference behaviour from the access rules, on a flat byte array.
    function automatic void model_access(input logic wr, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic flt);
        int size;
        logic sgn;
        logic uns;
        logic [31:0] val;
        size = 1; sgn = 1'b0; uns = 1'b0; flt = 1'b0; rd = 32'h0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1'b1; end
            3'd5: begin size = 2; uns = 1'b1; end
            default: flt = 1'b1;
        endcase
        if (wr && uns) flt = 1'b1;
        if (a >= DEPTH*4) flt = 1'b1;
        if (a % size != 0) flt = 1'b1;
        if (flt) return;
        if (wr) begin
            for (int k = 0; k < size; k++) model_bytes[a+k] = wd[8*k +: 8];
        end else begin
            val = 32'h0;
            for (int k = 0; k < size; k++) val = val | (32'(model_bytes[a+k]) << (8*k));
            if (sgn && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
            rd = val;
        end
    endfunction

    // One complete transaction on the WAIT_STATES=1 instance, fully checked.
    task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] exp_rd;
        logic        exp_flt;
        int          lat;
        logic        got;
        model_access(wr, f3, a, wd, exp_rd, exp_flt);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3;
        bus.req_address = a; bus.req_wdata = wd;
        @(negedge clk);
        check({tag, "_ready"}, MEMW'(bus.req_ready), MEMW'(1));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom); bus.req_funct3 = 3'($urandom);
        bus.req_address = $urandom; bus.req_wdata = $urandom;
        lat = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) begin got = 1'b1; break; end
        end
        if (!got) lat = -1;
        check({tag, "_latency"}, MEMW'(lat), MEMW'(WS + 1));
        last_rdata = bus.resp_rdata;
        last_fault = bus.resp_fault;
        check({tag, "_rdata"}, MEMW'(bus.resp_rdata), MEMW'(exp_rd));
        check({tag, "_fault"}, MEMW'(bus.resp_fault), MEMW'(exp_flt));
        check({tag, "_mem"}, mc, model_words());
        @(negedge clk);
        check({tag, "_oneshot"}, MEMW'(bus.resp_valid), MEMW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd_tmp, wa, wb, addr;
        logic        flt_tmp, rdy, seen, wr;
        logic [2:0]  f3;
        int          sel;
        longint      acc [$];
        logic        hist [$];
        longint      spacing;

        n_cmp = 0; n_fail = 0;
        for (int i = 0; i < DEPTH; i++) iv[i] = $urandom;
        iv[0] = 32'h8000_00FF;
        iv[1] = 32'h0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_address = 32'h0; bus.req_wdata = 32'h0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_funct3 = 3'b0;
        bus0.req_address = 32'h0; bus0.req_wdata = 32'h0;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready_low", MEMW'(bus.req_ready), MEMW'(0));
        check("rst_resp_valid", MEMW'(bus.resp_valid), MEMW'(0));
        check("rst_rdata", MEMW'(bus.resp_rdata), MEMW'(0));
        check("rst_fault", MEMW'(bus.resp_fault), MEMW'(0));
        check("rst_mem", mc, iv);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_high", MEMW'(bus.req_ready), MEMW'(1));
        model_reset();

        // Sub-word loads of 32'h8000_00FF
        do_req("lb0", 1'b0, 3'b000, 32'd0, 32'h0);
        check("plan_lb0", MEMW'(last_rdata), MEMW'(32'hFFFF_FFFF));
        do_req("lbu3", 1'b0, 3'b100, 32'd3, 32'h0);
        check("plan_lbu3", MEMW'(last_rdata), MEMW'(32'h0000_0080));
        do_req("lh2", 1'b0, 3'b001, 32'd2, 32'h0);
        check("plan_lh2", MEMW'(last_rdata), MEMW'(32'hFFFF_8000));
        do_req("lhu2", 1'b0, 3'b101, 32'd2, 32'h0);
        check("plan_lhu2", MEMW'(last_rdata), MEMW'(32'h0000_8000));

        // Sub-word stores into word 1
        do_req("sb5", 1'b1, 3'b000, 32'd5, 32'h1234_56AB);
        check("plan_sb5", MEMW'(mc[1]), MEMW'(32'h0000_AB00));
        do_req("sh6", 1'b1, 3'b001, 32'd6, 32'h0000_CDEF);
        check("plan_sh6", MEMW'(mc[1]), MEMW'(32'hCDEF_AB00));
        do_req("lw4", 1'b0, 3'b010, 32'd4, 32'h0);

        // Illegal accesses
        do_req("flt_lw6", 1'b0, 3'b010, 32'h6, 32'h0);
        check("plan_flt_lw6", MEMW'(last_fault), MEMW'(1));
        do_req("flt_sw80", 1'b1, 3'b010, 32'h80, 32'h1111_2222);
        check("plan_flt_sw80", MEMW'(last_fault), MEMW'(1));
        do_req("flt_f3_011", 1'b0, 3'b011, 32'h0, 32'h0);
        check("plan_flt_011", MEMW'(last_fault), MEMW'(1));
        do_req("flt_sbu", 1'b1, 3'b100, 32'h8, 32'hFFFF_FFFF);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) f3 = 3'($urandom_range(0, 7));
            else begin
                sel = $urandom_range(0, 4);
                f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
            end
            addr = $urandom_range(0, DEPTH*4 - 1);
            if ($urandom_range(0, 3) != 0) begin
                if (f3 == 3'b010) addr[1:0] = 2'b00;
                else if (f3 == 3'b001 || f3 == 3'b101) addr[0] = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) addr = addr + DEPTH*4;
            wr = 1'($urandom_range(0, 1));
            do_req($sformatf("rnd%0d", i), wr, f3, addr, $urandom);
        end

        // Back-to-back stores with req_valid held high
        wa = $urandom; wb = $urandom;
        model_access(1'b1, 3'b010, 32'd8, wa, rd_tmp, flt_tmp);
        model_access(1'b1, 3'b010, 32'd12, wb, rd_tmp, flt_tmp);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_address = 32'd8; bus.req_wdata = wa;
        for (int i = 0; i < 12 && acc.size() < 2; i++) begin
            @(negedge clk);
            rdy = bus.req_ready;
            hist.push_back(rdy);
            @(posedge clk);
            if (rdy) begin
                acc.push_back($time);
                #1;
                bus.req_address = 32'd12; bus.req_wdata = wb;
            end
        end
        bus.req_valid = 1'b0;
        check("pair_accepts", MEMW'(acc.size()), MEMW'(2));
        spacing = (acc.size() == 2) ? (acc[1] - acc[0]) / 10 : -1;
        check("pair_spacing", MEMW'(spacing), MEMW'(3));
        check("pair_ready_gap", MEMW'((hist.size() >= 3) ? {hist[1], hist[2]} : 2'b11), MEMW'(2'b00));
        @(negedge clk);
        check("pair2_ready_low1", MEMW'(bus.req_ready), MEMW'(0));
        @(negedge clk);
        check("pair2_ready_low2", MEMW'(bus.req_ready), MEMW'(0));
        check("pair2_resp", MEMW'(bus.resp_valid), MEMW'(1));
        check("pair_mem", mc, model_words());
        @(negedge clk);
        check("pair_idle_ready", MEMW'(bus.req_ready), MEMW'(1));

        // Reset while a store is waiting
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_address = 32'd0; bus.req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("midrst_in_wait", MEMW'(bus.req_ready), MEMW'(0));
        reset = 1'b1;
        #1;
        check("midrst_ready_low", MEMW'(bus.req_ready), MEMW'(0));
        check("midrst_mem", mc, iv);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", MEMW'(bus.req_ready), MEMW'(1));
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        check("midrst_no_resp", MEMW'(seen), MEMW'(0));
        check("midrst_word0", MEMW'(mc[0]), MEMW'(iv[0]));
        model_reset();
        do_req("post_rst_lw0", 1'b0, 3'b010, 32'd0, 32'h0);

        // Zero wait-state instance: held requests accepted every 2 cycles
        wa = $urandom; wb = $urandom;
        acc.delete(); hist.delete();
        @(posedge clk); #1;
        bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_funct3 = 3'b010;
        bus0.req_address = 32'd4; bus0.req_wdata = wa;
        for (int i = 0; i < 12 && acc.size() < 2; i++) begin
            @(negedge clk);
            rdy = bus0.req_ready;
            hist.push_back(rdy);
            @(posedge clk);
            if (rdy) begin
                acc.push_back($time);
                #1;
                bus0.req_wdata = wb;
            end
        end
        bus0.req_valid = 1'b0;
        spacing = (acc.size() == 2) ? (acc[1] - acc[0]) / 10 : -1;
        check("ws0_spacing", MEMW'(spacing), MEMW'(2));
        check("ws0_ready_gap", MEMW'((hist.size() >= 2) ? hist[1] : 1'b1), MEMW'(0));
        @(negedge clk);
        check("ws0_resp", MEMW'(bus0.resp_valid), MEMW'(1));
        check("ws0_word1", MEMW'(mc0[1]), MEMW'(wb));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
